muldiv_sequencer: RTL

Multi-cycle controller for the RV32M MUL/DIV/REM group, placed beside the single-cycle ALU in the EX stage.
- Accepts one M-extension op, runs an iterative shift-add multiply or restoring divide, and holds the pipeline via `stall` until the result is ready.
- Owns all sequencing: operand sign conditioning, iteration counting, final sign fix-up, and RISC-V corner-case results.

---
 rtl/muldiv_sequencer_pkg.sv | 38 +++
 rtl/muldiv_sequencer_if.sv | 25 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: funct3 op codes,
// sequencer states and small op-classification helpers.
package muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        MdMul    = 3'b000,
        MdMulh   = 3'b001,
        MdMulhsu = 3'b010,
        MdMulhu  = 3'b011,
        MdDiv    = 3'b100,
        MdDivu   = 3'b101,
        MdRem    = 3'b110,
        MdRemu   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MdsIdle = 2'd0,
        MdsCalc = 2'd1,
        MdsDone = 2'd2
    } mds_state_e;

    function automatic logic op_is_div(md_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(md_op_e op);
        return op inside {MdRem, MdRemu};
    endfunction

    function automatic logic rs1_signed(md_op_e op);
        return op inside {MdMul, MdMulh, MdMulhsu, MdDiv, MdRem};
    endfunction

    function automatic logic rs2_signed(md_op_e op);
        return op inside {MdMul, MdMulh, MdDiv, MdRem};
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Pipeline <-> multiply/divide sequencer handshake. The EX stage drives the
// op (master); the sequencer answers with stall/busy/done/result (slave).
interface muldiv_sequencer_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, funct3, rs1, rs2,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, kill, funct3, rs1, rs2,
        output stall, busy, done, result
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath on a 2*XLEN accumulator:
// shift-add multiply (multiplier in the low half) or restoring divide step.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_o
);
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] addend;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   top;
    logic            ge;
    logic [XLEN-1:0] diff;

    always_comb begin
        hi     = acc_i[2*XLEN-1:XLEN];
        lo     = acc_i[XLEN-1:0];
        addend = lo[0] ? b_i : '0;
        sum    = {1'b0, hi} + {1'b0, addend};
        // Remainder shifted left with the next dividend bit; may need XLEN+1 bits.
        top    = acc_i[2*XLEN-1:XLEN-1];
        ge     = top >= {1'b0, b_i};
        // When ge holds the true difference is below 2^XLEN, so XLEN-bit math is exact.
        diff   = top[XLEN-1:0] - b_i;
        if (is_div_i) begin
            acc_o = ge ? {diff, acc_i[XLEN-2:0], 1'b1}
                       : {top[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end else begin
            acc_o = {sum, lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M MUL/DIV/REM sequencer for the EX stage; holds the pipeline
// via stall until done. Optional MULDIV_EARLY_OUT_EN skips CALC for trivial ops.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input logic            clk,
    input logic            reset,
    muldiv_sequencer_if.slave md
);
    localparam int unsigned CntW = $clog2(XLEN);

    mds_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    md_op_e            op_q, op_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   result_q, result_d;

    md_op_e            op_in;
    logic              a_neg, b_neg, accept;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        op_in  = md_op_e'(md.funct3);
        a_neg  = rs1_signed(op_in) & md.rs1[XLEN-1];
        b_neg  = rs2_signed(op_in) & md.rs2[XLEN-1];
        a_abs  = a_neg ? -md.rs1 : md.rs1;
        b_abs  = b_neg ? -md.rs2 : md.rs2;
        accept = (state_q == MdsIdle) & md.start & ~md.kill;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            early_hit;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] early_res;

    always_comb begin
        div_zero = (md.rs2 == '0);
        div_ovf  = rs1_signed(op_in) & (md.rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&md.rs2);
        if (op_is_div(op_in)) begin
            early_hit = div_zero | div_ovf;
            if (op_is_rem(op_in)) begin
                early_res = div_zero ? md.rs1 : '0;
            end else begin
                early_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
            end
        end else begin
            early_hit = (md.rs1 == '0) | (md.rs2 == '0);
            early_res = '0;
        end
    end
`endif

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .is_div_i (op_is_div(op_q)),
        .acc_i    (acc_q),
        .b_i      (b_q),
        .acc_o    (acc_step)
    );

    // Sign fix-up on the final iteration's output, so the result registers
    // on the same edge that CALC ends.
    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        quo  = acc_step[XLEN-1:0];
        rem  = acc_step[2*XLEN-1:XLEN];
        unique case (op_q)
            MdMul:                    fix_res = prod[XLEN-1:0];
            MdMulh, MdMulhsu, MdMulhu: fix_res = prod[2*XLEN-1:XLEN];
            MdDiv, MdDivu:            fix_res = neg_q ? -quo : quo;
            default:                  fix_res = neg_q ? -rem : rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        b_d      = b_q;
        result_d = result_q;
        unique case (state_q)
            MdsIdle: begin
                if (accept) begin
                    op_d    = op_in;
                    cnt_d   = CntW'(XLEN - 1);
                    state_d = MdsCalc;
                    if (op_is_div(op_in)) begin
                        acc_d = {{XLEN{1'b0}}, a_abs};
                        b_d   = b_abs;
                        neg_d = op_is_rem(op_in) ? a_neg
                                                 : (a_neg ^ b_neg) & (md.rs2 != '0);
                    end else begin
                        acc_d = {{XLEN{1'b0}}, b_abs};
                        b_d   = a_abs;
                        neg_d = a_neg ^ b_neg;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    if (early_hit) begin
                        result_d = early_res;
                        state_d  = MdsDone;
                    end
`endif
                end
            end
            MdsCalc: begin
                if (md.kill) begin
                    state_d = MdsIdle;
                end else begin
                    acc_d = acc_step;
                    if (cnt_q == '0) begin
                        result_d = fix_res;
                        state_d  = MdsDone;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            MdsDone: state_d = MdsIdle;
            default: state_d = MdsIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MdsIdle;
            cnt_q    <= '0;
            op_q     <= MdMul;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign md.stall  = accept | (state_q == MdsCalc);
    assign md.busy   = (state_q != MdsIdle);
    assign md.done   = (state_q == MdsDone);
    assign md.result = result_q;
endmodule
